// File: rtl/id_stage.sv
// Decode stage: predicts JAL and backward branches (BTFN), detects load-use hazards,
// reads the regfile with writeback bypass and registers the decoded bundle for EX.
module id_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter bit          BTFN_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_pc,
    input  logic [31:0] imem_dout,
    input  logic        ex_br_mispred,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic        id_stall,
    output logic        id_target_taken,
    output logic [31:0] id_target,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic        ex_pred_taken
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic        id_valid_q;
    logic        id_live;
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  ex_rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        is_jal;
    logic        is_branch;
    logic        ex_is_load;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sel;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    assign opcode = imem_dout[6:0];
    assign rs1    = imem_dout[19:15];
    assign rs2    = imem_dout[24:20];
    assign rf_ra1 = rs1;
    assign rf_ra2 = rs2;
    assign ex_rd  = ex_inst[11:7];

    assign id_live    = id_valid_q & ~ex_br_mispred;
    assign is_jal     = (opcode == OPC_JAL);
    assign is_branch  = (opcode == OPC_BRANCH);
    assign ex_is_load = (ex_inst[6:0] == OPC_LOAD);
    assign uses_rs1   = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
    assign uses_rs2   = is_branch || (opcode == OPC_STORE) || (opcode == OPC_OP);

    assign imm_i = {{20{imem_dout[31]}}, imem_dout[31:20]};
    assign imm_s = {{20{imem_dout[31]}}, imem_dout[31:25], imem_dout[11:7]};
    assign imm_b = {{19{imem_dout[31]}}, imem_dout[31], imem_dout[7],
                    imem_dout[30:25], imem_dout[11:8], 1'b0};
    assign imm_u = {imem_dout[31:12], 12'b0};
    assign imm_j = {{11{imem_dout[31]}}, imem_dout[31], imem_dout[19:12],
                    imem_dout[20], imem_dout[30:21], 1'b0};

    always_comb begin
        imm_sel = 32'b0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_sel = imm_i;
            OPC_STORE:                      imm_sel = imm_s;
            OPC_BRANCH:                     imm_sel = imm_b;
            OPC_LUI, OPC_AUIPC:             imm_sel = imm_u;
            OPC_JAL:                        imm_sel = imm_j;
            default:                        imm_sel = 32'b0;
        endcase
    end

    // The load in EX only blocks an operand this instruction actually reads.
    assign id_stall = id_live & ex_valid & ex_is_load & (ex_rd != 5'd0)
                    & ((uses_rs1 & (ex_rd == rs1)) | (uses_rs2 & (ex_rd == rs2)));

    assign id_target_taken = id_live & ~id_stall
                           & (is_jal | (BTFN_EN & is_branch & imm_b[31]));
    assign id_target       = id_pc + (is_jal ? imm_j : imm_b);

    always_comb begin
        rs1_data = rf_rd1;
        if (rs1 == 5'd0) begin
            rs1_data = 32'b0;
        end else if (wb_we && (wb_rd == rs1)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = rf_rd2;
        if (rs2 == 5'd0) begin
            rs2_data = 32'b0;
        end else if (wb_we && (wb_rd == rs2)) begin
            rs2_data = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q    <= 1'b0;
            ex_valid      <= 1'b0;
            ex_pc         <= 32'b0;
            ex_inst       <= NOP_INST;
            ex_rs1_data   <= 32'b0;
            ex_rs2_data   <= 32'b0;
            ex_imm        <= 32'b0;
            ex_pred_taken <= 1'b0;
        end else begin
            id_valid_q <= 1'b1;
            if (!id_live || id_stall) begin
                ex_valid      <= 1'b0;
                ex_inst       <= NOP_INST;
                ex_pred_taken <= 1'b0;
            end else begin
                ex_valid      <= 1'b1;
                ex_pc         <= id_pc;
                ex_inst       <= imem_dout;
                ex_rs1_data   <= rs1_data;
                ex_rs2_data   <= rs2_data;
                ex_imm        <= imm_sel;
                ex_pred_taken <= id_target_taken;
            end
        end
    end
endmodule
